sccb_multi_cam_config: RTL and testbench
========================================

Name: sccb_multi_cam_config

Overview:
- Parametrised successor to the single-camera OV7670 configuration controller.
- Sequences an external register ROM into an external SCCB sender (i2c_sender handshake) for NUM_CAMS cameras in turn, selecting the bus through cam_sel.
- Adds the following, which the single-camera controller lacks: a camera reset/wake phase, in-ROM delay and end commands, per-camera done flags, a resend request that never aborts a transfer, and a parametrised xclk divider.

Parameters:
- NUM_CAMS, 2, number of cameras configured in order 0..NUM_CAMS-1.
- CAM_ADDR, 8'h42, SCCB write ID driven on i2c_id.
- ADDR_W, 8, ROM address width.
- XCLK_DIV, 2, clk cycles per xclk period; must be even and >=2.
- RESET_CYCLES, 16, clk cycles cam_reset is held low, and also the wake wait after release.
- DELAY_CYCLES, 1000000, clk cycles stalled per DELAY_CMD.
- END_CMD, 16'hFFFF, ROM word ending one camera's list.
- DELAY_CMD, 16'hFFF0, ROM word inserting a stall.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- resend  in  1  one-cycle pulse requesting reconfiguration of all cameras
- rom_addr  out  ADDR_W  register ROM address
- rom_data  in  16  {reg,value}; registered ROM, valid 1 cycle after rom_addr
- i2c_send  out  1  request to SCCB sender
- i2c_id  out  8  equals CAM_ADDR
- i2c_reg  out  8  register address
- i2c_value  out  8  register data
- i2c_taken  in  1  one-cycle pulse: sender accepted the current command
- cam_sel  out  max(1,clog2(NUM_CAMS))  index of the bus/camera being configured
- config_finished  out  NUM_CAMS  bit n set once camera n is configured
- all_finished  out  1  all bits of config_finished set
- cam_reset  out  NUM_CAMS  active-low camera reset
- pwdn  out  NUM_CAMS  tied 0
- xclk  out  1  camera clock, clk/XCLK_DIV, 50% duty cycle

Behaviour:
- Reset values: rom_addr=0, i2c_send=0, i2c_reg/value=0, cam_sel=0, config_finished=0, all_finished=0, cam_reset=0 (asserted), xclk=0, resend_pending=0, state=RST_HOLD.
- rst asserted in any state, including SEND, returns all outputs to reset values on the next edge. The sender is not drained.
- xclk: a free-running counter toggles xclk every XCLK_DIV/2 clk cycles. Only rst stops it.
- RST_HOLD: cam_reset=0 for RESET_CYCLES cycles, then cam_reset=all 1 and go to WAKE.
- WAKE: wait RESET_CYCLES cycles, then go to FETCH.
- FETCH: rom_addr is stable; go to DECODE in 1 cycle to cover ROM latency.
- DECODE: act on rom_data.
  - END_CMD, or rom_addr = 2^ADDR_W-1 (overrun guard): set config_finished[cam_sel]. If cam_sel<NUM_CAMS-1, increment cam_sel, set rom_addr=0 and go to FETCH. Otherwise go to DONE.
  - DELAY_CMD: load the counter with DELAY_CYCLES, go to DELAY.
  - Otherwise: latch i2c_reg=rom_data[15:8] and i2c_value=rom_data[7:0], go to SEND.
- SEND: i2c_send=1 and held until i2c_taken. i2c_reg/value are stable while i2c_send=1. On the taken cycle, i2c_send drops on the next edge, rom_addr increments, go to FETCH.
  - A taken pulse is accepted only in SEND; taken outside SEND is ignored.
- DELAY: counts down to 0, then rom_addr increments and go to FETCH.
- DONE: idle, i2c_send=0, all_finished=1.
- Per-command latency: FETCH (1) + DECODE (1) + SEND (>=1 until taken). The first send of each camera begins 2 cycles after entering FETCH with rom_addr=0.
- resend:
  - Sets resend_pending in any state.
  - Acted on only at a FETCH, DELAY or DONE boundary, never inside SEND, so an in-flight SCCB transfer always completes.
  - Action: clear config_finished and all_finished, set cam_sel=0, rom_addr=0, resend_pending=0, go to FETCH. cam_reset stays high and no reset hold is performed.
  - resend coinciding with i2c_taken in SEND: the taken is honoured first; reconfiguration starts at the following FETCH.
  - resend during rst: ignored.
- Width rules:
  - rom_addr wraps only via the overrun guard, never silently.
  - cam_sel never exceeds NUM_CAMS-1.
  - NUM_CAMS=1 gives cam_sel constant 0.

Test Plan:
- Power-up, NUM_CAMS=1, ROM {1280, 1204, FFFF}, sender acks 3 cycles after send: cam_reset low 16 cycles then high; two sends carrying reg/value 12/80 then 12/04; config_finished=1 and all_finished=1; no further send.
- NUM_CAMS=2, same ROM: cam_sel=0 for the first two sends, then 1 for the next two, rom_addr restarting at 0; config_finished goes 01 then 11.
- ROM {FFF0, 1180, FFFF} with DELAY_CYCLES=100: the first i2c_send rises no earlier than 100 cycles after the DECODE of FFF0.
- resend pulsed while i2c_send=1: i2c_send stays high until taken; then config_finished is cleared, rom_addr=0, and the sequence reruns with no cam_reset pulse.
- rst asserted mid-SEND: next cycle i2c_send=0, xclk=0, cam_reset=0, config_finished=0; the full sequence restarts after the reset hold and wake.
- XCLK_DIV=4: xclk period is 4 clk cycles, 2 high and 2 low. ROM with no FFFF and ADDR_W=3: config_finished sets at rom_addr=7 via the overrun guard.

Source files
------------

// File: rtl/sccb_multi_cam_config.sv
// Multi-camera SCCB configuration sequencer: reset/wake each camera, then stream
// the register ROM into an i2c_sender for every camera in turn, with delays and resend.
module sccb_multi_cam_config #(
    parameter int unsigned NUM_CAMS     = 2,
    parameter logic [7:0]  CAM_ADDR     = 8'h42,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned XCLK_DIV     = 2,
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned DELAY_CYCLES = 1000000,
    parameter logic [15:0] END_CMD      = 16'hFFFF,
    parameter logic [15:0] DELAY_CMD    = 16'hFFF0,
    localparam int unsigned CS_W        = (NUM_CAMS > 1) ? $clog2(NUM_CAMS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                resend,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [15:0]         rom_data,
    output logic                i2c_send,
    output logic [7:0]          i2c_id,
    output logic [7:0]          i2c_reg,
    output logic [7:0]          i2c_value,
    input  logic                i2c_taken,
    output logic [CS_W-1:0]     cam_sel,
    output logic [NUM_CAMS-1:0] config_finished,
    output logic                all_finished,
    output logic [NUM_CAMS-1:0] cam_reset,
    output logic [NUM_CAMS-1:0] pwdn,
    output logic                xclk
);

    localparam int unsigned HALF_DIV = XCLK_DIV / 2;
    localparam int unsigned XC_W     = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int unsigned CNT_MAX  = (DELAY_CYCLES > RESET_CYCLES) ? DELAY_CYCLES : RESET_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        RST_HOLD,
        WAKE,
        FETCH,
        DECODE,
        SEND,
        DELAY,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic                i2c_send_q, i2c_send_d;
    logic [7:0]          i2c_reg_q, i2c_reg_d;
    logic [7:0]          i2c_value_q, i2c_value_d;
    logic [CS_W-1:0]     cam_sel_q, cam_sel_d;
    logic [NUM_CAMS-1:0] cfg_done_q, cfg_done_d;
    logic                all_done_q, all_done_d;
    logic [NUM_CAMS-1:0] cam_reset_q, cam_reset_d;
    logic                resend_pending_q, resend_pending_d;
    logic                xclk_q, xclk_d;
    logic [XC_W-1:0]     xclk_cnt_q, xclk_cnt_d;
    logic                resend_now;
    logic                restart;

    // A resend arriving this very cycle is honoured at the same boundary as a stored one.
    assign resend_now = resend_pending_q | resend;

    // Free-running xclk divider; only rst stops it.
    always_comb begin
        xclk_cnt_d = xclk_cnt_q + XC_W'(1);
        xclk_d     = xclk_q;
        if (xclk_cnt_q == XC_W'(HALF_DIV - 1)) begin
            xclk_cnt_d = '0;
            xclk_d     = ~xclk_q;
        end
    end

    // Sequencer next-state and outputs.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        rom_addr_d       = rom_addr_q;
        i2c_send_d       = 1'b0;
        i2c_reg_d        = i2c_reg_q;
        i2c_value_d      = i2c_value_q;
        cam_sel_d        = cam_sel_q;
        cfg_done_d       = cfg_done_q;
        cam_reset_d      = cam_reset_q;
        resend_pending_d = resend_now;
        restart          = 1'b0;

        case (state_q)
            RST_HOLD: begin
                cam_reset_d = '0;
                if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                    cnt_d       = '0;
                    cam_reset_d = '1;
                    state_d     = WAKE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAKE: begin
                if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FETCH: begin
                if (resend_now) begin
                    restart = 1'b1;
                end else begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // The last ROM word always ends the list so rom_addr never wraps silently.
                if ((rom_data == END_CMD) || (rom_addr_q == '1)) begin
                    cfg_done_d[cam_sel_q] = 1'b1;
                    if (cam_sel_q != CS_W'(NUM_CAMS - 1)) begin
                        cam_sel_d  = cam_sel_q + CS_W'(1);
                        rom_addr_d = '0;
                        state_d    = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end else if (rom_data == DELAY_CMD) begin
                    cnt_d   = CNT_W'(DELAY_CYCLES);
                    state_d = DELAY;
                end else begin
                    i2c_reg_d   = rom_data[15:8];
                    i2c_value_d = rom_data[7:0];
                    i2c_send_d  = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (i2c_taken) begin
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    state_d    = FETCH;
                end else begin
                    i2c_send_d = 1'b1;
                end
            end
            DELAY: begin
                if (resend_now) begin
                    restart = 1'b1;
                end else if (cnt_q == '0) begin
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    state_d    = FETCH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (resend_now) begin
                    restart = 1'b1;
                end
            end
            default: state_d = RST_HOLD;
        endcase

        // Reconfiguration keeps cameras out of reset and skips the hold/wake phase.
        if (restart) begin
            cfg_done_d       = '0;
            cam_sel_d        = '0;
            rom_addr_d       = '0;
            resend_pending_d = 1'b0;
            state_d          = FETCH;
        end

        all_done_d = &cfg_done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= RST_HOLD;
            cnt_q            <= '0;
            rom_addr_q       <= '0;
            i2c_send_q       <= 1'b0;
            i2c_reg_q        <= '0;
            i2c_value_q      <= '0;
            cam_sel_q        <= '0;
            cfg_done_q       <= '0;
            all_done_q       <= 1'b0;
            cam_reset_q      <= '0;
            resend_pending_q <= 1'b0;
            xclk_q           <= 1'b0;
            xclk_cnt_q       <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            rom_addr_q       <= rom_addr_d;
            i2c_send_q       <= i2c_send_d;
            i2c_reg_q        <= i2c_reg_d;
            i2c_value_q      <= i2c_value_d;
            cam_sel_q        <= cam_sel_d;
            cfg_done_q       <= cfg_done_d;
            all_done_q       <= all_done_d;
            cam_reset_q      <= cam_reset_d;
            resend_pending_q <= resend_pending_d;
            xclk_q           <= xclk_d;
            xclk_cnt_q       <= xclk_cnt_d;
        end
    end

    assign rom_addr        = rom_addr_q;
    assign i2c_send        = i2c_send_q;
    assign i2c_id          = CAM_ADDR;
    assign i2c_reg         = i2c_reg_q;
    assign i2c_value       = i2c_value_q;
    assign cam_sel         = cam_sel_q;
    assign config_finished = cfg_done_q;
    assign all_finished    = all_done_q;
    assign cam_reset       = cam_reset_q;
    assign pwdn            = '0;
    assign xclk            = xclk_q;

endmodule

// File: tb/tb_sccb_multi_cam_config.sv
// Randomised bench for sccb_multi_cam_config: a transaction-level model predicts
// the ordered list of SCCB writes per camera; timing pins are hand-derived.
module tb_sccb_multi_cam_config;

    localparam int unsigned NCAM  = 2;
    localparam int unsigned AW    = 4;
    localparam int unsigned XDIV  = 4;
    localparam int unsigned RC    = 16;
    localparam int unsigned DC    = 20;
    localparam int unsigned ROM_N = 1 << AW;
    localparam int FIRST_SEND_K   = 2 * RC + 2;

    typedef struct packed {
        logic [7:0] cam;
        logic [7:0] rg;
        logic [7:0] val;
    } cmd_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            resend;
    logic [AW-1:0]   rom_addr;
    logic [15:0]     rom_data;
    logic            i2c_send;
    logic [7:0]      i2c_id;
    logic [7:0]      i2c_reg;
    logic [7:0]      i2c_value;
    logic            i2c_taken;
    logic [0:0]      cam_sel;
    logic [NCAM-1:0] config_finished;
    logic            all_finished;
    logic [NCAM-1:0] cam_reset;
    logic [NCAM-1:0] pwdn;
    logic            xclk;

    sccb_multi_cam_config #(
        .NUM_CAMS    (NCAM),
        .CAM_ADDR    (8'h42),
        .ADDR_W      (AW),
        .XCLK_DIV    (XDIV),
        .RESET_CYCLES(RC),
        .DELAY_CYCLES(DC),
        .END_CMD     (16'hFFFF),
        .DELAY_CMD   (16'hFFF0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .resend         (resend),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .i2c_send       (i2c_send),
        .i2c_id         (i2c_id),
        .i2c_reg        (i2c_reg),
        .i2c_value      (i2c_value),
        .i2c_taken      (i2c_taken),
        .cam_sel        (cam_sel),
        .config_finished(config_finished),
        .all_finished   (all_finished),
        .cam_reset      (cam_reset),
        .pwdn           (pwdn),
        .xclk           (xclk)
    );

    always #5 clk = ~clk;

    logic [15:0] rom_mem [ROM_N];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   k        = 0;
    bit   started  = 1'b0;
    cmd_t exp_q[$];
    bit   rebuild_pending = 1'b0;
    int   resend_budget   = 0;
    int   resend_pct      = 0;
    bit   resend_cam1_only = 1'b0;
    bit   done_resend_req = 1'b0;
    int   wait_cnt        = 0;
    int   first_send_k    = -1;
    bit   seen_first      = 1'b0;
    int   addr_at_fin0    = -1;
    logic            prev_send = 1'b0;
    logic [7:0]      prev_reg, prev_val;
    logic [0:0]      prev_sel;
    logic [NCAM-1:0] prev_cf = '0;
    logic [AW-1:0]   prev_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected write list: every camera walks the same ROM from address 0.
    function automatic void build_model();
        logic [15:0] w;
        exp_q.delete();
        for (int c = 0; c < int'(NCAM); c++) begin
            for (int a = 0; a < int'(ROM_N); a++) begin
                w = rom_mem[a];
                if (w == 16'hFFFF || a == int'(ROM_N) - 1) break;
                if (w == 16'hFFF0) continue;
                exp_q.push_back({8'(c), w[15:8], w[7:0]});
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    // Per-cycle compare against the rule-level model.
    always @(negedge clk) begin
        if (started) begin
            check("i2c_id", 32'(i2c_id), 32'h42);
            check("pwdn", 32'(pwdn), 32'h0);
            check("xclk", 32'(xclk), 32'((k / int'(XDIV / 2)) % 2));
            check("cam_reset", 32'(cam_reset), (k >= int'(RC)) ? 32'h3 : 32'h0);
            check("all_finished", 32'(all_finished), 32'(config_finished == '1));
            if (k < FIRST_SEND_K) check("early_send", 32'(i2c_send), 32'h0);
            if (k == 2) check("xclk_pin_hi", 32'(xclk), 32'h1);
            if (k == 4) check("xclk_pin_lo", 32'(xclk), 32'h0);
            if (prev_send && i2c_send) begin
                check("hold_reg", 32'(i2c_reg), 32'(prev_reg));
                check("hold_value", 32'(i2c_value), 32'(prev_val));
                check("hold_cam_sel", 32'(cam_sel), 32'(prev_sel));
            end
            if (i2c_send && !seen_first) begin
                first_send_k = k;
                seen_first   = 1'b1;
            end
            if (config_finished[0] && !prev_cf[0]) addr_at_fin0 = int'(prev_addr);
            if (config_finished == '0 && prev_cf != '0) begin
                check("restart_rom_addr", 32'(rom_addr), 32'h0);
                check("restart_cam_sel", 32'(cam_sel), 32'h0);
            end
        end
        prev_send = i2c_send;
        prev_reg  = i2c_reg;
        prev_val  = i2c_value;
        prev_sel  = cam_sel;
        prev_cf   = config_finished;
        prev_addr = rom_addr;
    end

    // Sender model plus resend stimulus; owns i2c_taken and resend.
    always @(negedge clk) begin
        i2c_taken = 1'b0;
        resend    = 1'b0;
        if (!started || rst) begin
            wait_cnt = int'($urandom_range(0, 3));
        end else if (i2c_send) begin
            if (resend_budget > 0 && int'($urandom_range(0, 99)) < resend_pct &&
                (!resend_cam1_only || cam_sel == 1'b1)) begin
                resend          = 1'b1;
                rebuild_pending = 1'b1;
                resend_budget--;
            end
            if (wait_cnt == 0) begin
                i2c_taken = 1'b1;
                wait_cnt  = int'($urandom_range(0, 3));
                if (exp_q.size() == 0) begin
                    check("unexpected_send", 32'h1, 32'h0);
                end else begin
                    cmd_t e;
                    e = exp_q.pop_front();
                    check("send_cam_sel", 32'(cam_sel), 32'(e.cam));
                    check("send_reg", 32'(i2c_reg), 32'(e.rg));
                    check("send_value", 32'(i2c_value), 32'(e.val));
                    check("send_finished", 32'(config_finished), (32'h1 << e.cam) - 32'h1);
                end
                if (rebuild_pending) begin
                    build_model();
                    rebuild_pending = 1'b0;
                end
            end else begin
                wait_cnt--;
            end
        end else if (done_resend_req && all_finished) begin
            resend          = 1'b1;
            done_resend_req = 1'b0;
            build_model();
        end else begin
            i2c_taken = ($urandom_range(0, 7) == 0);
        end
    end

    // Called at a negedge: one reset edge, check reset values, restart the model.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        started = 1'b1;
        check("rst_rom_addr", 32'(rom_addr), 32'h0);
        check("rst_i2c_send", 32'(i2c_send), 32'h0);
        check("rst_i2c_reg", 32'(i2c_reg), 32'h0);
        check("rst_i2c_value", 32'(i2c_value), 32'h0);
        check("rst_cam_sel", 32'(cam_sel), 32'h0);
        check("rst_config_finished", 32'(config_finished), 32'h0);
        check("rst_all_finished", 32'(all_finished), 32'h0);
        check("rst_cam_reset", 32'(cam_reset), 32'h0);
        check("rst_xclk", 32'(xclk), 32'h0);
        build_model();
        rebuild_pending = 1'b0;
        seen_first      = 1'b0;
        first_send_k    = -1;
        addr_at_fin0    = -1;
        rst = 1'b0;
    endtask

    task automatic run_to_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (all_finished && exp_q.size() == 0 && !rebuild_pending && !done_resend_req) begin
                ok = 1'b1;
                break;
            end
        end
        check({"done_", name}, 32'(ok), 32'h1);
    endtask

    task automatic check_idle();
        int sends = 0;
        check("idle_config_finished", 32'(config_finished), 32'h3);
        check("idle_all_finished", 32'(all_finished), 32'h1);
        check("idle_queue_left", 32'(exp_q.size()), 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i2c_send) sends++;
        end
        check("idle_extra_sends", 32'(sends), 32'h0);
    endtask

    task automatic load_basic();
        for (int a = 0; a < int'(ROM_N); a++) rom_mem[a] = 16'hFFFF;
        rom_mem[0] = 16'h1280;
        rom_mem[1] = 16'h1204;
    endtask

    initial begin
        rst       = 1'b1;
        resend    = 1'b0;
        i2c_taken = 1'b0;
        load_basic();
        @(negedge clk);

        // Power-up with two cameras sharing a short list.
        do_reset();
        run_to_done("basic");
        check("first_send_cycle", 32'(first_send_k), 32'(FIRST_SEND_K));
        check("end_at_addr", 32'(addr_at_fin0), 32'h2);
        check_idle();

        // Resend while camera 1 is mid-transfer.
        resend_budget = 1; resend_pct = 100; resend_cam1_only = 1'b1;
        do_reset();
        run_to_done("resend_in_send");
        check_idle();
        resend_budget = 0; resend_cam1_only = 1'b0;

        // Resend from the idle state.
        do_reset();
        run_to_done("pre_idle_resend");
        done_resend_req = 1'b1;
        run_to_done("idle_resend");
        check_idle();

        // In-ROM delay ahead of the only command.
        for (int a = 0; a < int'(ROM_N); a++) rom_mem[a] = 16'hFFFF;
        rom_mem[0] = 16'hFFF0;
        rom_mem[1] = 16'h1180;
        do_reset();
        run_to_done("delay");
        check("delay_first_send", 32'(first_send_k >= int'(2 * RC + 1 + DC)), 32'h1);
        check_idle();

        // No end marker: the overrun guard ends each list at the last address.
        for (int a = 0; a < int'(ROM_N); a++) rom_mem[a] = 16'($urandom_range(0, 32'hFFEF));
        do_reset();
        run_to_done("overrun");
        check("overrun_addr", 32'(addr_at_fin0), 32'(ROM_N - 1));
        check_idle();

        // Reset in the middle of camera 1's first transfer.
        load_basic();
        do_reset();
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (config_finished == 2'b01 && i2c_send) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("reach_mid_send", 32'(hit), 32'h1);
        end
        do_reset();
        run_to_done("after_mid_rst");
        check("rerun_first_send", 32'(first_send_k), 32'(FIRST_SEND_K));
        check_idle();

        // Random lists with random delays, sender latency and resends.
        for (int s = 0; s < 8; s++) begin
            int n;
            n = int'($urandom_range(0, ROM_N - 1));
            for (int a = 0; a < int'(ROM_N); a++) rom_mem[a] = 16'($urandom_range(0, 32'hFFEF));
            for (int a = 0; a < n; a++) if ($urandom_range(0, 5) == 0) rom_mem[a] = 16'hFFF0;
            if (n < int'(ROM_N) - 1) rom_mem[n] = 16'hFFFF;
            resend_budget = 2; resend_pct = 10;
            do_reset();
            run_to_done("random");
            if (s % 2 == 1) begin
                done_resend_req = 1'b1;
                run_to_done("random_idle_resend");
            end
            check_idle();
            resend_budget = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
